// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - fixed-latency 128-bit line memory model answering cache pmem requests
module pmem_responder #(
  parameter int LATENCY    = 4,
  parameter int INDEX_BITS = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata,
  output logic         busy,
  output logic         proto_err
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam logic [3:0] LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                 state, state_nx;
  logic [3:0]             cnt, cnt_nx;
  logic                   op_write;
  logic [INDEX_BITS-1:0]  lat_index;
  logic [11:0]            lat_addr;
  logic [127:0]           lat_wdata;
  logic [127:0]           mem [LINES];
  logic [LINES-1:0]       valid;

  logic                   req;
  logic                   accept;
  logic                   set_err;
  logic                   rd_fire;
  logic [INDEX_BITS-1:0]  in_index;
  logic [INDEX_BITS-1:0]  rd_index;

  assign req      = pmem_read | pmem_write;
  assign in_index = pmem_address[INDEX_BITS+3:4];
  assign busy     = (state != IDLE);
  assign pmem_resp = (state == RESP);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    set_err  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept   = 1'b1;
          cnt_nx   = LOAD;
          state_nx = (LATENCY == 1) ? RESP : BUSY;
          set_err  = pmem_read & pmem_write;
        end
      end
      BUSY: begin
        if (!req) begin
          state_nx = IDLE;
          cnt_nx   = 4'd0;
        end else begin
          // The latched request completes regardless; a change only flags the violation.
          if ((pmem_write != op_write) || (pmem_address[15:4] != lat_addr))
            set_err = 1'b1;
          if (cnt == 4'd0)
            state_nx = RESP;
          else
            cnt_nx = cnt - 4'd1;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // With LATENCY=1 the read fires on the accepting edge, before the latches are loaded.
  assign rd_index = accept ? in_index : lat_index;
  assign rd_fire  = (state_nx == RESP) && !(accept ? pmem_write : op_write);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      op_write   <= 1'b0;
      lat_index  <= '0;
      lat_addr   <= 12'd0;
      lat_wdata  <= '0;
      pmem_rdata <= '0;
      proto_err  <= 1'b0;
      valid      <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        op_write  <= pmem_write;
        lat_index <= in_index;
        lat_addr  <= pmem_address[15:4];
        lat_wdata <= pmem_wdata;
      end
      if (set_err)
        proto_err <= 1'b1;
      if (rd_fire)
        pmem_rdata <= valid[rd_index] ? mem[rd_index] : '0;
      if ((state == RESP) && op_write)
        valid[lat_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && (state == RESP) && op_write)
      mem[lat_index] <= lat_wdata;
  end

endmodule

// File: tb/tb_pmem_responder.sv
// tb/tb_pmem_responder.sv - scoreboard bench for pmem_responder (LATENCY=4 and LATENCY=1 builds)
module tb_pmem_responder;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         rd, wr;
  logic [15:0]  addr;
  logic [127:0] wdata;
  logic         resp, busy, err;
  logic [127:0] rdata;

  logic         rd1, wr1;
  logic [15:0]  addr1;
  logic [127:0] wdata1;
  logic         resp1, busy1, err1;
  logic [127:0] rdata1;

  always #5 clk = ~clk;

  pmem_responder #(.LATENCY(LAT), .INDEX_BITS(6)) u_dut (
    .clk(clk), .reset_n(reset_n), .pmem_read(rd), .pmem_write(wr),
    .pmem_address(addr), .pmem_wdata(wdata), .pmem_resp(resp),
    .pmem_rdata(rdata), .busy(busy), .proto_err(err)
  );

  pmem_responder #(.LATENCY(1), .INDEX_BITS(6)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .pmem_read(rd1), .pmem_write(wr1),
    .pmem_address(addr1), .pmem_wdata(wdata1), .pmem_resp(resp1),
    .pmem_rdata(rdata1), .busy(busy1), .proto_err(err1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic         is_read;
    logic [127:0] data;
    string        tag;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [127:0] exp_last = '0;
  logic [127:0] m_mem [64];
  logic [63:0]  m_val = '0;

  localparam logic [127:0] D_A = 128'hDEADBEEF_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] D_B = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D_C = 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] D_Z = 128'h5A5A_5A5A_A5A5_A5A5_0F0F_0F0F_F0F0_F0F0;

  always @(posedge clk) begin
    #1;
    if (reset_n && resp) begin
      if (sb.size() == 0) begin
        chk("spurious_resp", 128'd1, 128'd0);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_read) begin
          chk(mon_e.tag, rdata, mon_e.data);
          exp_last = mon_e.data;
        end else begin
          chk({mon_e.tag, "_rdata_kept"}, rdata, exp_last);
        end
      end
    end
  end

  task automatic push_exp(input logic is_rd, input logic [15:0] a, input logic [127:0] d,
                          input string tag);
    exp_t e;
    int   idx;
    idx = int'(a[9:4]);
    e.is_read = is_rd;
    e.tag = tag;
    if (is_rd) begin
      e.data = m_val[idx] ? m_mem[idx] : '0;
    end else begin
      e.data = d;
      m_mem[idx] = d;
      m_val[idx] = 1'b1;
    end
    sb.push_back(e);
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!resp && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_req(input logic r, input logic w, input logic [15:0] a,
                        input logic [127:0] d, input string tag);
    int n;
    push_exp(!w, a, d, tag);
    rd = r; wr = w; addr = a; wdata = d;
    @(posedge clk); #1;
    wait_resp(n);
    chk({tag, "_lat"}, 128'(n), 128'(LAT));
    rd = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_idle"}, 128'(busy), 128'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    sb.delete();
    m_val = '0;
    exp_last = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    rd = 0; wr = 0; addr = '0; wdata = '0;
    rd1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp", 128'(resp), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_rdata", rdata, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;

    do_req(1, 0, 16'h1230, '0, "rd_unwritten");
    do_req(0, 1, 16'h0040, D_A, "wr_0040");
    do_req(1, 0, 16'h0048, '0, "rd_0048");
    do_req(1, 0, 16'h0440, '0, "rd_alias_0440");
    do_req(0, 1, 16'h0FF0, D_C, "wr_top_line");
    do_req(1, 0, 16'hFFF0, '0, "rd_top_alias");

    // held read: second pulse LATENCY+1 cycles after the first one ends
    push_exp(1, 16'h0040, '0, "held_rd1");
    push_exp(1, 16'h0040, '0, "held_rd2");
    rd = 1; addr = 16'h0040;
    @(posedge clk); #1;
    wait_resp(n);
    chk("held_first_lat", 128'(n), 128'(LAT));
    @(posedge clk); #1;
    chk("held_gap_low", 128'(resp), 128'd0);
    wait_resp(n);
    chk("held_gap", 128'(n), 128'(LAT + 1));
    rd = 0;
    @(posedge clk); #1;

    // aborted write leaves previous contents
    do_req(0, 1, 16'h0080, D_B, "wr_0080");
    wr = 1; addr = 16'h0080; wdata = D_Z;
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end
    wr = 0;
    @(posedge clk); #1;
    chk("abort_busy", 128'(busy), 128'd0);
    repeat (8) @(posedge clk);
    #1;
    do_req(1, 0, 16'h0080, '0, "rd_after_abort");
    chk("abort_no_err", 128'(err), 128'd0);

    // address change mid-flight: latched write completes, error flagged
    push_exp(0, 16'h0100, D_Z, "wr_addr_change");
    wr = 1; addr = 16'h0100; wdata = D_Z;
    @(posedge clk); #1;
    addr = 16'h0200; wdata = D_B;
    wait_resp(n);
    chk("addr_change_lat", 128'(n), 128'(LAT));
    wr = 0;
    @(posedge clk); #1;
    chk("addr_change_err", 128'(err), 128'd1);
    do_req(1, 0, 16'h0100, '0, "rd_0100");
    do_req(1, 0, 16'h0200, '0, "rd_0200");

    pulse_reset();
    chk("err_cleared", 128'(err), 128'd0);
    do_req(1, 0, 16'h0040, '0, "rd_after_reset");

    // both requests high: write wins, sticky error
    do_req(1, 1, 16'h00C0, D_C, "both_wr");
    chk("both_err", 128'(err), 128'd1);
    do_req(1, 0, 16'h00C0, '0, "rd_00C0");
    chk("err_sticky", 128'(err), 128'd1);

    // reset during BUSY discards the request
    rd = 1; addr = 16'h00C0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset_n = 1'b0;
    sb.delete();
    m_val = '0;
    exp_last = '0;
    #1;
    chk("rst_mid_busy", 128'(busy), 128'd0);
    chk("rst_mid_resp", 128'(resp), 128'd0);
    chk("rst_mid_rdata", rdata, 128'd0);
    chk("rst_mid_err", 128'(err), 128'd0);
    rd = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    do_req(1, 0, 16'h00C0, '0, "rd_after_mid_rst");

    // LATENCY=1 build
    rd1 = 1; addr1 = 16'h0010;
    @(posedge clk); #1;
    chk("l1_rd_resp", 128'(resp1), 128'd1);
    chk("l1_rd_data", rdata1, 128'd0);
    rd1 = 0;
    @(posedge clk); #1;
    chk("l1_resp_one_cycle", 128'(resp1), 128'd0);
    wr1 = 1; addr1 = 16'h0010; wdata1 = D_B;
    @(posedge clk); #1;
    chk("l1_wr_resp", 128'(resp1), 128'd1);
    wr1 = 0;
    @(posedge clk); #1;
    rd1 = 1;
    @(posedge clk); #1;
    chk("l1_rd2_resp", 128'(resp1), 128'd1);
    chk("l1_rd2_data", rdata1, D_B);
    rd1 = 0;
    @(posedge clk); #1;

    chk("sb_drained", 128'(sb.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
